stopwatch_lap_ctrl: RTL and testbench
=====================================

Name: stopwatch_lap_ctrl

Overview:
Parametrised stopwatch command controller and the successor to the three-button stopwatch FSM. It adds a lap/split capture buffer with recall, a configurable tick divider, count width and limit, a configurable stop timeout, and a sticky overflow flag. It sits between the debounced button block and the FND/segment display driver, and drives the status LEDs.

Parameters:
TICK_DIV, 10, number of `tick` strobes per count increment (10 ms resolution with a 1 ms tick)
CNT_W, 14, width of the running count and of each lap entry
CNT_MAX, 9999, last count value before wrap to 0; must be < 2**CNT_W
STOP_TIMEOUT, 500, count-pulses spent in STOP or RECALL with no button before returning to IDLE
LAP_DEPTH, 4, lap buffer entries, ≥2

Ports:
clk100Mhz  in  1  system clock
rstN  in  1  asynchronous active-low reset
tick  in  1  1-cycle timebase strobe
btnDb  in  4  debounced, level: [0] arm, [1] start/stop, [2] clear, [3] lap/recall
idle  out  1  high in IDLE
led  out  5  one-hot state: [4] IDLE … [0] RECALL (order IDLE, WAIT, CNT, STOP, RECALL)
segData  out  CNT_W  value to display
lapIdx  out  clog2(LAP_DEPTH)  age of the displayed lap (0 = newest); 0 outside RECALL
lapCnt  out  clog2(LAP_DEPTH+1)  number of valid laps, saturates at LAP_DEPTH
ovf  out  1  sticky: running count has wrapped

Behaviour:
- Reset values (rstN low): state IDLE, led 5'b10000, idle 1, segData 0, lapIdx 0, lapCnt 0, ovf 0, all internal counters 0, previous-button register 0.
- Edge detect: rise[i] = btnDb[i] & ~btnPrev[i]; btnPrev is registered every clock. A held button yields exactly one rise.
- Pulse generator:
  - divCnt counts `tick`.
  - When tick && divCnt == TICK_DIV-1: divCnt goes to 0 and `pulse` is high for the next single cycle.
  - `pulse` is low on every other cycle.
  - The generator free-runs in all states.
- Priority when several rises occur in one cycle: clear > start/stop > lap. Only the highest-priority rise is acted on; the others are dropped.
- FSM transitions (evaluated every clock):
  - IDLE: rise[0] -> WAIT. All other buttons are ignored.
  - WAIT: rise[1] -> CNT. rise[2] -> WAIT (performs clear).
  - CNT: rise[1] -> STOP. rise[2] -> WAIT (clear). rise[3] captures a lap and stays in CNT.
  - STOP: rise[1] -> CNT. rise[2] -> WAIT (clear). rise[3] with lapCnt > 0 -> RECALL, lapIdx = 0. rise[3] with lapCnt == 0 is ignored. Timeout -> IDLE.
  - RECALL:
    - rise[3] -> lapIdx = (lapIdx == lapCnt-1) ? 0 : lapIdx+1.
    - rise[1] -> STOP, lapIdx = 0.
    - rise[2] -> WAIT (clear).
    - Timeout -> IDLE.
- Clear: takes effect on the clock edge of the transition, not on a pulse. Running count = 0, lapCnt = 0, ovf = 0, write pointer = 0.
- Running count:
  - Increments only on `pulse` while in CNT.
  - At CNT_MAX it wraps to 0 and sets ovf.
  - Holds in every other state. IDLE entered by timeout keeps the count.
- Lap capture:
  - Writes the running-count register value of the capture cycle. A pulse in that same cycle still increments the live count; the captured value is the pre-increment value.
  - The buffer is circular. When full, the oldest entry is overwritten and lapCnt stays at LAP_DEPTH.
- Timeout counter:
  - Counts pulses while in STOP or RECALL.
  - Cleared on any rise[1..3] and on any entry to STOP or RECALL.
  - When it reaches STOP_TIMEOUT-1 with a pulse -> IDLE.
  - Cleared in all other states.
- segData: the lap entry at age lapIdx in RECALL; the running count otherwise. Registered; updates one cycle after the state or index change.
- rstN asserted mid-count or mid-recall: everything returns to reset values immediately (asynchronous). Laps are lost.

Decomposition:
- Package stopwatch_pkg:
  - State encoding localparams IDLE=0, WAIT=1, CNT=2, STOP=3, RECALL=4 (3-bit).
  - Button indices BTN_ARM, BTN_RUN, BTN_CLR, BTN_LAP.
- One sub-module, lap_buffer (params DEPTH, W):
  - Inputs: wr, clr, rdAge.
  - Outputs: rdData, count.
  - Holds the circular write pointer and resolves age to slot as (wrPtr-1-rdAge) mod DEPTH.
- The FSM, divider, running count and timeout counter stay in the top module.

Test Plan:
Run all scenarios with TICK_DIV=2, CNT_MAX=9, STOP_TIMEOUT=5, LAP_DEPTH=4, and tick strobed every 4 clocks.
1. Reset then arm, run: rise0, rise1, then 6 ticks -> exactly 3 pulses, segData=3, led=5'b00100.
2. Wrap: run 12 pulses from 0 -> segData=2, ovf=1. Then rise2 -> segData=0, ovf=0, state WAIT.
3. Laps: in CNT, press lap at counts 1,3,5,7,8 -> lapCnt=4. Then stop and lap -> RECALL, segData=8. Three more laps -> 7, 5, 3. One more lap -> 8 (entry 1 overwritten).
4. Simultaneous: rise1 and rise3 in the same cycle in CNT -> STOP, no lap captured (lapCnt unchanged).
5. Timeout: STOP with no buttons for 5 pulses -> IDLE, idle=1, segData holds the last count. A rise1 at pulse 4 restarts the 5-pulse timeout.
6. Async reset: drop rstN mid-cycle in RECALL -> all outputs return to reset values with no clock edge. Empty STOP plus lap -> stays STOP.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap controller.
// Holds the controller state encoding and the bit positions of the
// debounced buttons.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    CNT    = 3'd2,
    STOP   = 3'd3,
    RECALL = 3'd4
  } swState_t;

  localparam int unsigned BTN_ARM = 0;
  localparam int unsigned BTN_RUN = 1;
  localparam int unsigned BTN_CLR = 2;
  localparam int unsigned BTN_LAP = 3;

endpackage

// File: rtl/lap_buffer.sv
// Circular lap capture buffer.
// Ports:
//   clk100Mhz, rstN : clock, async active-low reset
//   wr, wrData      : capture wrData into the next slot
//   clr             : forget all entries (pointer and count to 0)
//   rdAge           : age of entry to read (0 = newest)
//   rdData          : entry at rdAge
//   count           : valid entries, saturates at DEPTH
module lap_buffer
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 14
) (
  input  logic                         clk100Mhz,
  input  logic                         rstN,
  input  logic                         wr,
  input  logic                         clr,
  input  logic [W-1:0]                 wrData,
  input  logic [$clog2(DEPTH)-1:0]     rdAge,
  output logic [W-1:0]                 rdData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW:0]   slotSum;
  logic [AW-1:0] rdSlot;

  // (wrPtr-1-rdAge) mod DEPTH, done with one extra bit and a single
  // conditional subtract so non-power-of-two depths also work.
  always_comb begin
    slotSum = {1'b0, wrPtr} + DEPTH_X - (AW+1)'(1) - {1'b0, rdAge};
    rdSlot  = (slotSum >= DEPTH_X) ? AW'(slotSum - DEPTH_X) : AW'(slotSum);
    rdData  = mem[rdSlot];
  end

  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wrPtr <= '0;
      count <= '0;
    end else if (wr) begin
      mem[wrPtr] <= wrData;
      wrPtr      <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch command controller with lap capture and recall.
// Ports:
//   clk100Mhz, rstN : clock, async active-low reset
//   tick            : 1-cycle timebase strobe
//   btnDb[3:0]      : debounced buttons {lap, clear, start/stop, arm}
//   idle            : high in IDLE
//   led[4:0]        : one-hot state {IDLE, WAIT, CNT, STOP, RECALL}
//   segData         : displayed value (lap entry in RECALL, else count)
//   lapIdx          : age of displayed lap, 0 outside RECALL
//   lapCnt          : valid laps, saturating
//   ovf             : sticky running-count wrap flag
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 10,
  parameter int unsigned CNT_W        = 14,
  parameter int unsigned CNT_MAX      = 9999,
  parameter int unsigned STOP_TIMEOUT = 500,
  parameter int unsigned LAP_DEPTH    = 4
) (
  input  logic                             clk100Mhz,
  input  logic                             rstN,
  input  logic                             tick,
  input  logic [3:0]                       btnDb,
  output logic                             idle,
  output logic [4:0]                       led,
  output logic [CNT_W-1:0]                 segData,
  output logic [$clog2(LAP_DEPTH)-1:0]     lapIdx,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lapCnt,
  output logic                             ovf
);

  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;
  localparam int unsigned IW = $clog2(LAP_DEPTH);
  localparam int unsigned LW = $clog2(LAP_DEPTH + 1);

  swState_t      state, stateNext;
  logic [3:0]    btnPrev, rise;
  logic [DW-1:0] divCnt;
  logic          pulse;
  logic [CNT_W-1:0] cnt;
  logic [TW-1:0] toCnt;
  logic [IW-1:0] lapIdxNext;
  logic [CNT_W-1:0] lapData;
  logic          doClr, doLap, anyRise, timeoutHit, inHold;

  assign rise    = btnDb & ~btnPrev;
  assign anyRise = |rise[3:1];
  assign inHold  = (state == STOP) || (state == RECALL);
  // A rise in the same cycle restarts the timeout, so it cannot also fire.
  assign timeoutHit = pulse && !anyRise && (toCnt == TW'(STOP_TIMEOUT - 1));

  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      btnPrev <= '0;
      divCnt  <= '0;
      pulse   <= 1'b0;
      lapIdx  <= '0;
    end else begin
      state   <= stateNext;
      btnPrev <= btnDb;
      lapIdx  <= lapIdxNext;
      pulse   <= tick && (divCnt == DW'(TICK_DIV - 1));
      if (tick) divCnt <= (divCnt == DW'(TICK_DIV - 1)) ? '0 : divCnt + DW'(1);
    end
  end

  // Clear > start/stop > lap; the if-else chains drop lower rises.
  always_comb begin
    stateNext  = state;
    lapIdxNext = lapIdx;
    doClr      = 1'b0;
    doLap      = 1'b0;
    unique case (state)
      IDLE: if (rise[BTN_ARM]) stateNext = WAIT;
      WAIT: begin
        if (rise[BTN_CLR])      doClr = 1'b1;
        else if (rise[BTN_RUN]) stateNext = CNT;
      end
      CNT: begin
        if (rise[BTN_CLR])      begin doClr = 1'b1; stateNext = WAIT; end
        else if (rise[BTN_RUN]) stateNext = STOP;
        else if (rise[BTN_LAP]) doLap = 1'b1;
      end
      STOP: begin
        if (rise[BTN_CLR])      begin doClr = 1'b1; stateNext = WAIT; end
        else if (rise[BTN_RUN]) stateNext = CNT;
        else if (rise[BTN_LAP]) begin
          if (lapCnt != '0) begin stateNext = RECALL; lapIdxNext = '0; end
        end
        else if (timeoutHit)    stateNext = IDLE;
      end
      RECALL: begin
        if (rise[BTN_CLR])      begin doClr = 1'b1; stateNext = WAIT; end
        else if (rise[BTN_RUN]) stateNext = STOP;
        else if (rise[BTN_LAP])
          lapIdxNext = (LW'(lapIdx) == lapCnt - LW'(1)) ? '0 : lapIdx + IW'(1);
        else if (timeoutHit)    stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (stateNext != RECALL) lapIdxNext = '0;
  end

  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) begin
      cnt   <= '0;
      ovf   <= 1'b0;
      toCnt <= '0;
    end else begin
      if (doClr) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else if (state == CNT && pulse) begin
        if (cnt == CNT_W'(CNT_MAX)) begin
          cnt <= '0;
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      if (!inHold || anyRise || stateNext != state) toCnt <= '0;
      else if (pulse)                               toCnt <= toCnt + TW'(1);
    end
  end

  always_ff @(posedge clk100Mhz or negedge rstN) begin
    if (!rstN) segData <= '0;
    else       segData <= (state == RECALL) ? lapData : cnt;
  end

  always_comb begin
    led = 5'b10000;
    unique case (state)
      IDLE:    led = 5'b10000;
      WAIT:    led = 5'b01000;
      CNT:     led = 5'b00100;
      STOP:    led = 5'b00010;
      RECALL:  led = 5'b00001;
      default: led = 5'b10000;
    endcase
  end

  assign idle = (state == IDLE);

  lap_buffer #(
    .DEPTH(LAP_DEPTH),
    .W    (CNT_W)
  ) uLapBuf (
    .clk100Mhz(clk100Mhz),
    .rstN     (rstN),
    .wr       (doLap),
    .clr      (doClr),
    .wrData   (cnt),
    .rdAge    (lapIdx),
    .rdData   (lapData),
    .count    (lapCnt)
  );

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl (small parameter set).
module tb_stopwatch_lap_ctrl;

  localparam int unsigned TICK_DIV     = 2;
  localparam int unsigned CNT_W        = 14;
  localparam int unsigned CNT_MAX      = 9;
  localparam int unsigned STOP_TIMEOUT = 5;
  localparam int unsigned LAP_DEPTH    = 4;

  localparam int unsigned L_IDLE = 5'b10000;
  localparam int unsigned L_WAIT = 5'b01000;
  localparam int unsigned L_CNT  = 5'b00100;
  localparam int unsigned L_STOP = 5'b00010;
  localparam int unsigned L_REC  = 5'b00001;

  localparam logic [3:0] B_ARM = 4'b0001;
  localparam logic [3:0] B_RUN = 4'b0010;
  localparam logic [3:0] B_CLR = 4'b0100;
  localparam logic [3:0] B_LAP = 4'b1000;

  logic clk100Mhz = 1'b0;
  logic rstN;
  logic tick;
  logic [3:0] btnDb;
  logic idle;
  logic [4:0] led;
  logic [CNT_W-1:0] segData;
  logic [$clog2(LAP_DEPTH)-1:0] lapIdx;
  logic [$clog2(LAP_DEPTH+1)-1:0] lapCnt;
  logic ovf;

  stopwatch_lap_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .CNT_W       (CNT_W),
    .CNT_MAX     (CNT_MAX),
    .STOP_TIMEOUT(STOP_TIMEOUT),
    .LAP_DEPTH   (LAP_DEPTH)
  ) dut (
    .clk100Mhz(clk100Mhz),
    .rstN     (rstN),
    .tick     (tick),
    .btnDb    (btnDb),
    .idle     (idle),
    .led      (led),
    .segData  (segData),
    .lapIdx   (lapIdx),
    .lapCnt   (lapCnt),
    .ovf      (ovf)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  typedef enum int {SIG_SEG, SIG_LED, SIG_IDLE, SIG_IDX, SIG_LCNT, SIG_OVF} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    int unsigned exp;
  } exp_t;

  exp_t sbQ[$];
  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      SIG_SEG:  return 32'(segData);
      SIG_LED:  return 32'(led);
      SIG_IDLE: return 32'(idle);
      SIG_IDX:  return 32'(lapIdx);
      SIG_LCNT: return 32'(lapCnt);
      default:  return 32'(ovf);
    endcase
  endfunction

  task automatic pushExp(input string tag, input sig_e s, input int unsigned v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sbQ.push_back(e);
  endtask

  task automatic checkAll();
    exp_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal(e.tag, observe(e.sig), 32'(e.exp));
    end
  endtask

  // One button edge, then enough clocks for state and segData to settle.
  task automatic press(input logic [3:0] mask);
    @(negedge clk100Mhz) btnDb = mask;
    @(negedge clk100Mhz) btnDb = '0;
    repeat (2) @(negedge clk100Mhz);
  endtask

  // Ticks every 4 clocks; even counts give n/2 count pulses.
  task automatic runTicks(input int unsigned n);
    repeat (n) begin
      @(negedge clk100Mhz) tick = 1'b1;
      @(negedge clk100Mhz) tick = 1'b0;
      repeat (2) @(negedge clk100Mhz);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rstN = 1'b0; tick = 1'b0; btnDb = '0;
    repeat (3) @(negedge clk100Mhz);
    pushExp("rst_led", SIG_LED, L_IDLE);
    pushExp("rst_idle", SIG_IDLE, 1);
    pushExp("rst_seg", SIG_SEG, 0);
    pushExp("rst_idx", SIG_IDX, 0);
    pushExp("rst_lcnt", SIG_LCNT, 0);
    pushExp("rst_ovf", SIG_OVF, 0);
    checkAll();
    rstN = 1'b1;
    repeat (2) @(negedge clk100Mhz);

    // 1. arm, run, 6 ticks -> 3 pulses
    press(B_ARM);
    pushExp("arm_led", SIG_LED, L_WAIT); pushExp("arm_idle", SIG_IDLE, 0);
    checkAll();
    press(B_RUN);
    runTicks(6);
    pushExp("run3_seg", SIG_SEG, 3); pushExp("run3_led", SIG_LED, L_CNT);
    checkAll();

    // 2. wrap through CNT_MAX
    press(B_CLR);
    pushExp("clr1_seg", SIG_SEG, 0); pushExp("clr1_led", SIG_LED, L_WAIT);
    checkAll();
    press(B_RUN);
    runTicks(24);
    pushExp("wrap_seg", SIG_SEG, 2); pushExp("wrap_ovf", SIG_OVF, 1);
    checkAll();
    press(B_CLR);
    pushExp("clr2_seg", SIG_SEG, 0); pushExp("clr2_ovf", SIG_OVF, 0);
    pushExp("clr2_led", SIG_LED, L_WAIT);
    checkAll();

    // 3. laps at 1,3,5,7,8 then recall
    press(B_RUN);
    runTicks(2); press(B_LAP);
    pushExp("lap1_lcnt", SIG_LCNT, 1); checkAll();
    runTicks(4); press(B_LAP);
    runTicks(4); press(B_LAP);
    runTicks(4); press(B_LAP);
    runTicks(2); press(B_LAP);
    pushExp("lap5_lcnt", SIG_LCNT, 4); pushExp("lap5_seg", SIG_SEG, 8);
    checkAll();
    press(B_RUN);
    pushExp("stop_led", SIG_LED, L_STOP); checkAll();
    press(B_LAP);
    pushExp("rec0_led", SIG_LED, L_REC); pushExp("rec0_seg", SIG_SEG, 8);
    pushExp("rec0_idx", SIG_IDX, 0);
    checkAll();
    press(B_LAP);
    pushExp("rec1_seg", SIG_SEG, 7); pushExp("rec1_idx", SIG_IDX, 1); checkAll();
    press(B_LAP);
    pushExp("rec2_seg", SIG_SEG, 5); checkAll();
    press(B_LAP);
    pushExp("rec3_seg", SIG_SEG, 3); pushExp("rec3_idx", SIG_IDX, 3); checkAll();
    press(B_LAP);
    pushExp("recw_seg", SIG_SEG, 8); pushExp("recw_idx", SIG_IDX, 0); checkAll();

    // 4. run+lap together: stop wins, no capture of 9
    press(B_RUN);
    pushExp("r2s_led", SIG_LED, L_STOP); pushExp("r2s_seg", SIG_SEG, 8); checkAll();
    press(B_RUN);
    runTicks(2);
    press(B_RUN | B_LAP);
    pushExp("sim_led", SIG_LED, L_STOP); pushExp("sim_seg", SIG_SEG, 9);
    pushExp("sim_lcnt", SIG_LCNT, 4);
    checkAll();
    press(B_LAP);
    pushExp("sim_newest", SIG_SEG, 8); checkAll();

    // 5. RECALL timeout restarted by a lap rise
    runTicks(8);
    pushExp("rto4_led", SIG_LED, L_REC); checkAll();
    press(B_LAP);
    runTicks(8);
    pushExp("rto_restart_led", SIG_LED, L_REC); pushExp("rto_restart_seg", SIG_SEG, 7);
    checkAll();
    runTicks(2);
    pushExp("rto_led", SIG_LED, L_IDLE); pushExp("rto_idle", SIG_IDLE, 1);
    pushExp("rto_seg", SIG_SEG, 9); pushExp("rto_idx", SIG_IDX, 0);
    checkAll();
    // STOP timeout, restarted by leaving and re-entering STOP at pulse 4
    press(B_ARM); press(B_RUN); press(B_RUN);
    runTicks(8);
    pushExp("sto4_led", SIG_LED, L_STOP); checkAll();
    press(B_RUN); press(B_RUN);
    runTicks(8);
    pushExp("sto_restart_led", SIG_LED, L_STOP); checkAll();
    runTicks(2);
    pushExp("sto_led", SIG_LED, L_IDLE); pushExp("sto_idle", SIG_IDLE, 1);
    pushExp("sto_seg", SIG_SEG, 9);
    checkAll();

    // 6. async reset in RECALL, then empty STOP + lap
    press(B_ARM); press(B_RUN); press(B_RUN); press(B_LAP);
    pushExp("pre_led", SIG_LED, L_REC); pushExp("pre_seg", SIG_SEG, 8); checkAll();
    @(negedge clk100Mhz);
    #2 rstN = 1'b0;
    #1;
    pushExp("arst_led", SIG_LED, L_IDLE); pushExp("arst_idle", SIG_IDLE, 1);
    pushExp("arst_seg", SIG_SEG, 0); pushExp("arst_idx", SIG_IDX, 0);
    pushExp("arst_lcnt", SIG_LCNT, 0); pushExp("arst_ovf", SIG_OVF, 0);
    checkAll();
    @(negedge clk100Mhz) rstN = 1'b1;
    press(B_ARM); press(B_RUN); press(B_RUN); press(B_LAP);
    pushExp("empty_led", SIG_LED, L_STOP); pushExp("empty_idx", SIG_IDX, 0);
    pushExp("empty_lcnt", SIG_LCNT, 0); pushExp("empty_seg", SIG_SEG, 0);
    checkAll();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
